// File: rtl/accum_multi_nbits.sv
// Multi-channel running-sum accumulator with read-and-clear readout,
// wrap/saturate overflow handling and a one-channel-per-cycle clear sweep.
module accum_multi_nbits #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int NCH       = 4,
    parameter bit SATURATE  = 1'b0,
    localparam int CH_W     = $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CH_W-1:0]      ch_i,
    input  logic [WIDTH-1:0]     x_i,
    input  logic                 rd_req_i,
    input  logic [CH_W-1:0]      rd_ch_i,
    output logic                 rd_valid_o,
    output logic [ACC_WIDTH-1:0] rd_data_o,
    output logic                 rd_ovf_o,
    input  logic                 clear_all_i,
    output logic                 busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     idx;
    logic [CH_W-1:0]     idx_nxt;

    logic [ACC_WIDTH-1:0] acc     [NCH];
    logic [ACC_WIDTH-1:0] acc_nxt [NCH];
    logic                 ovf     [NCH];
    logic                 ovf_nxt [NCH];

    logic                 add_fire;
    logic                 rd_fire;
    logic                 rd_ch_ok;
    logic [ACC_WIDTH:0]   x_ext;

    assign in_ready_o = (state == IDLE);
    assign busy_o     = (state == SWEEP);
    assign add_fire   = (state == IDLE) && in_valid_i;
    assign rd_fire    = (state == IDLE) && rd_req_i;
    assign rd_ch_ok   = int'(rd_ch_i) < NCH;
    assign x_ext      = {{(ACC_WIDTH - WIDTH + 1){1'b0}}, x_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (clear_all_i) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                idx_nxt = idx + 1'b1;
                if (idx == CH_W'(NCH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A read clears the channel first, so a same-edge add restarts from zero.
    always_comb begin
        logic [ACC_WIDTH-1:0] base;
        logic                 base_ovf;
        logic [ACC_WIDTH:0]   sum;
        for (int c = 0; c < NCH; c++) begin
            base     = acc[c];
            base_ovf = ovf[c];
            if (rd_fire && rd_ch_i == CH_W'(c)) begin
                base     = '0;
                base_ovf = 1'b0;
            end
            sum        = {1'b0, base} + x_ext;
            acc_nxt[c] = base;
            ovf_nxt[c] = base_ovf;
            if (add_fire && ch_i == CH_W'(c)) begin
                if (sum[ACC_WIDTH]) begin
                    acc_nxt[c] = SATURATE ? {ACC_WIDTH{1'b1}}
                                          : sum[ACC_WIDTH-1:0];
                    ovf_nxt[c] = 1'b1;
                end else begin
                    acc_nxt[c] = sum[ACC_WIDTH-1:0];
                end
            end
            if (state == SWEEP && idx == CH_W'(c)) begin
                acc_nxt[c] = '0;
                ovf_nxt[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                ovf[c] <= 1'b0;
            end
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_ovf_o   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= acc_nxt[c];
                ovf[c] <= ovf_nxt[c];
            end
            rd_valid_o <= rd_fire;
            if (rd_fire) begin
                rd_data_o <= rd_ch_ok ? acc[rd_ch_i] : '0;
                rd_ovf_o  <= rd_ch_ok ? ovf[rd_ch_i] : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_multi_nbits.sv
// Bench for accum_multi_nbits: wrap and saturate instances share stimulus,
// each checked against a per-channel arithmetic reference model.
module tb_accum_multi_nbits;

    localparam int W  = 8;
    localparam int AW = 10;
    localparam int N  = 4;
    localparam int MX = (1 << AW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, rd_req, clear_all;
    logic [1:0]   ch, rd_ch;
    logic [W-1:0] x;

    logic          ready_w, rv_w, ro_w, busy_w;
    logic [AW-1:0] rd_w;
    logic          ready_s, rv_s, ro_s, busy_s;
    logic [AW-1:0] rd_s;

    int n_chk = 0;
    int n_fail = 0;

    int m_acc [2][N];
    bit m_ovf [2][N];
    int sweep_left;
    bit e_rv;
    int e_rd [2];
    bit e_ro [2];

    accum_multi_nbits #(.WIDTH(W), .ACC_WIDTH(AW), .NCH(N), .SATURATE(1'b0)) dut_w (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ready_w),
        .ch_i(ch), .x_i(x), .rd_req_i(rd_req), .rd_ch_i(rd_ch),
        .rd_valid_o(rv_w), .rd_data_o(rd_w), .rd_ovf_o(ro_w),
        .clear_all_i(clear_all), .busy_o(busy_w)
    );

    accum_multi_nbits #(.WIDTH(W), .ACC_WIDTH(AW), .NCH(N), .SATURATE(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ready_s),
        .ch_i(ch), .x_i(x), .rd_req_i(rd_req), .rd_ch_i(rd_ch),
        .rd_valid_o(rv_s), .rd_data_o(rd_s), .rd_ovf_o(ro_s),
        .clear_all_i(clear_all), .busy_o(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: read value is captured, read channel zeroed, then the add
    // applied; a sweep zeroes channel (N - remaining) per edge.
    task automatic model();
        int s;
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < N; c++) begin
                    m_acc[d][c] = 0;
                    m_ovf[d][c] = 0;
                end
            sweep_left = 0;
            e_rv = 0;
            return;
        end
        if (sweep_left > 0) begin
            for (int d = 0; d < 2; d++) begin
                m_acc[d][N - sweep_left] = 0;
                m_ovf[d][N - sweep_left] = 0;
            end
            sweep_left--;
            e_rv = 0;
            return;
        end
        e_rv = rd_req;
        for (int d = 0; d < 2; d++) begin
            if (rd_req) begin
                e_rd[d] = m_acc[d][rd_ch];
                e_ro[d] = m_ovf[d][rd_ch];
                m_acc[d][rd_ch] = 0;
                m_ovf[d][rd_ch] = 0;
            end
            if (in_valid) begin
                s = m_acc[d][ch] + int'(x);
                if (s > MX) begin
                    m_ovf[d][ch] = 1;
                    m_acc[d][ch] = (d == 1) ? MX : s - (MX + 1);
                end else begin
                    m_acc[d][ch] = s;
                end
            end
        end
        if (clear_all) sweep_left = N;
    endtask

    task automatic compare();
        chk("ready_w", 32'(ready_w), 32'(sweep_left == 0));
        chk("ready_s", 32'(ready_s), 32'(sweep_left == 0));
        chk("busy_w", 32'(busy_w), 32'(sweep_left != 0));
        chk("busy_s", 32'(busy_s), 32'(sweep_left != 0));
        chk("rvalid_w", 32'(rv_w), 32'(e_rv));
        chk("rvalid_s", 32'(rv_s), 32'(e_rv));
        if (e_rv) begin
            chk("rdata_w", 32'(rd_w), 32'(e_rd[0]));
            chk("rdata_s", 32'(rd_s), 32'(e_rd[1]));
            chk("rovf_w", 32'(ro_w), 32'(e_ro[0]));
            chk("rovf_s", 32'(ro_s), 32'(e_ro[1]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model();
        #1;
        compare();
    endtask

    task automatic idle_in();
        rst = 0; in_valid = 0; rd_req = 0; clear_all = 0;
        ch = 0; rd_ch = 0; x = 0;
    endtask

    task automatic add(input int c, input int v);
        in_valid = 1; ch = 2'(c); x = 8'(v);
        cycle();
        idle_in();
    endtask

    task automatic rd(input int c);
        rd_req = 1; rd_ch = 2'(c);
        cycle();
        idle_in();
    endtask

    task automatic add_rd(input int c, input int v);
        in_valid = 1; ch = 2'(c); x = 8'(v);
        rd_req = 1; rd_ch = 2'(c);
        cycle();
        idle_in();
    endtask

    initial begin
        idle_in();
        sweep_left = 0;
        e_rv = 0;
        rst = 1;
        cycle();
        cycle();
        chk("rst_rdata", 32'(rd_w), 0);
        chk("rst_rovf", 32'(ro_w), 0);
        idle_in();

        for (int c = 0; c < N; c++) begin
            rd(c);
            chk("t1_zero", 32'(rd_s), 0);
        end

        repeat (3) add(1, 200);
        rd(1);
        chk("t2_600_w", 32'(rd_w), 600);
        chk("t2_600_s", 32'(rd_s), 600);
        rd(1);
        chk("t2_clr", 32'(rd_w), 0);
        rd(2);
        chk("t2_other", 32'(rd_w), 0);

        repeat (5) add(0, 255);
        rd(0);
        chk("t3_wrap", 32'(rd_w), 251);
        chk("t3_wovf", 32'(ro_w), 1);
        chk("t3_sat", 32'(rd_s), 1023);
        chk("t3_sovf", 32'(ro_s), 1);

        add(2, 10);
        add_rd(2, 5);
        chk("t4_pre", 32'(rd_w), 10);
        rd(2);
        chk("t4_post", 32'(rd_w), 5);
        chk("t4_ovf", 32'(ro_w), 0);

        for (int c = 0; c < N; c++) add(c, 100 + c);
        clear_all = 1;
        cycle();
        in_valid = 1; ch = 0; x = 7;
        rd_req = 1; rd_ch = 1;
        for (int i = 0; i < N; i++) begin
            chk("t5_busy", 32'(busy_w), 1);
            chk("t5_nrdy", 32'(ready_s), 0);
            cycle();
        end
        chk("t5_done", 32'(busy_w), 0);
        idle_in();
        for (int c = 0; c < N; c++) begin
            rd(c);
            chk("t5_zero", 32'(rd_w), 0);
        end

        for (int c = 0; c < N; c++) add(c, 50 + c);
        clear_all = 1;
        cycle();
        idle_in();
        cycle();
        rst = 1;
        cycle();
        idle_in();
        chk("t6_busy", 32'(busy_s), 0);
        chk("t6_rdy", 32'(ready_w), 1);
        for (int c = 0; c < N; c++) begin
            rd(c);
            chk("t6_zero", 32'(rd_s), 0);
        end

        repeat (2000) begin
            rst = ($urandom_range(0, 299) == 0);
            if (sweep_left == 0) begin
                in_valid  = 1'($urandom_range(0, 1));
                ch        = 2'($urandom);
                x         = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                rd_req    = ($urandom_range(0, 7) == 0);
                rd_ch     = 2'($urandom);
                clear_all = ($urandom_range(0, 59) == 0);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
